// File: rtl/anim_sequencer.sv
// Animation controller: walks the pixel datapath through background, per-channel
// coordinate generation, plot, frame-paced wait, erase and optional screen clear.
module anim_sequencer #(
  parameter int NUM_CH    = 4,
  parameter int CH_W      = 2,
  parameter int FRAME_DIV = 4,
  parameter int STEPS     = 60,
  parameter int STEP_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              black,
  input  logic              hit,
  input  logic              clr_done,
  input  logic              bg_done,
  input  logic              plot_done,
  input  logic              frame_tick,
  output logic              ld_clear,
  output logic              ld_bg,
  output logic              ld_coord,
  output logic              ld_plot,
  output logic              ld_erase,
  output logic [CH_W-1:0]   chan,
  output logic [STEP_W-1:0] step,
  output logic              round_done,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRAW_BG = 3'd1,
    S_GEN     = 3'd2,
    S_DRAW    = 3'd3,
    S_WAIT    = 3'd4,
    S_ERASE   = 3'd5,
    S_CLEAR   = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0]   CH_ONE     = CH_W'(1);
  localparam logic [7:0]        FRAME_LAST = 8'(FRAME_DIV - 1);
  localparam logic [STEP_W-1:0] STEPS_C    = STEP_W'(STEPS);
  localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);

  state_t              state_r, state_nx_s;
  logic [CH_W-1:0]     chan_r, chan_nx_s;
  logic [STEP_W-1:0]   step_r, step_nx_s;
  logic [7:0]          frame_cnt_r, frame_nx_s;
  logic                hit_q_r, hit_nx_s;
  logic                black_q_r, black_nx_s;

  logic                chan_last_s;
  logic [CH_W-1:0]     chan_inc_s;
  logic [STEP_W-1:0]   step_inc_s;
  logic                last_step_s;

  assign chan_last_s = (chan_r == LAST_CH);
  assign chan_inc_s  = chan_r + CH_ONE;
  // step saturates so it can never wrap past the round length
  assign step_inc_s  = (step_r < STEPS_C) ? (step_r + STEP_ONE) : step_r;
  assign last_step_s = ((step_r + STEP_ONE) == STEPS_C);
  assign chan        = chan_r;
  assign step        = step_r;

  // next-state and counter update logic
  always_comb begin
    state_nx_s = state_r;
    chan_nx_s  = chan_r;
    step_nx_s  = step_r;
    frame_nx_s = frame_cnt_r;
    hit_nx_s   = hit_q_r;
    black_nx_s = black_q_r;
    case (state_r)
      S_IDLE: begin
        if (go) begin
          state_nx_s = S_DRAW_BG;
          chan_nx_s  = '0;
          step_nx_s  = '0;
          frame_nx_s = 8'd0;
          hit_nx_s   = 1'b0;
          black_nx_s = 1'b0;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_DRAW_BG: begin
        if (bg_done) begin
          state_nx_s = S_GEN;
          chan_nx_s  = '0;
        end else begin
          state_nx_s = S_DRAW_BG;
        end
      end
      S_GEN: begin
        if (chan_last_s) begin
          state_nx_s = S_DRAW;
          chan_nx_s  = '0;
        end else begin
          chan_nx_s  = chan_inc_s;
        end
      end
      S_DRAW, S_ERASE: begin
        hit_nx_s   = hit_q_r | hit;
        black_nx_s = black_q_r | black;
        if (plot_done && chan_last_s) begin
          state_nx_s = (state_r == S_DRAW) ? S_WAIT : S_GEN;
          chan_nx_s  = '0;
        end else if (plot_done) begin
          chan_nx_s  = chan_inc_s;
        end else begin
          chan_nx_s  = chan_r;
        end
      end
      S_WAIT: begin
        // requests arriving on the exit cycle are dropped, not carried over
        if (frame_tick && (frame_cnt_r == FRAME_LAST)) begin
          frame_nx_s = 8'd0;
          step_nx_s  = step_inc_s;
          hit_nx_s   = 1'b0;
          black_nx_s = 1'b0;
          if (hit_q_r || last_step_s) begin
            state_nx_s = S_DONE;
          end else if (black_q_r) begin
            state_nx_s = S_CLEAR;
          end else begin
            state_nx_s = S_ERASE;
          end
        end else begin
          hit_nx_s   = hit_q_r | hit;
          black_nx_s = black_q_r | black;
          if (frame_tick) begin
            frame_nx_s = frame_cnt_r + 8'd1;
          end else begin
            frame_nx_s = frame_cnt_r;
          end
        end
      end
      S_CLEAR: begin
        if (clr_done) begin
          state_nx_s = S_DRAW_BG;
        end else begin
          state_nx_s = S_CLEAR;
        end
      end
      S_DONE: begin
        state_nx_s = S_IDLE;
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // state, counters and registered Moore decode of the next state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      chan_r      <= '0;
      step_r      <= '0;
      frame_cnt_r <= 8'd0;
      hit_q_r     <= 1'b0;
      black_q_r   <= 1'b0;
      ld_clear    <= 1'b0;
      ld_bg       <= 1'b0;
      ld_coord    <= 1'b0;
      ld_plot     <= 1'b0;
      ld_erase    <= 1'b0;
      round_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      chan_r      <= chan_nx_s;
      step_r      <= step_nx_s;
      frame_cnt_r <= frame_nx_s;
      hit_q_r     <= hit_nx_s;
      black_q_r   <= black_nx_s;
      ld_clear    <= (state_nx_s == S_CLEAR);
      ld_bg       <= (state_nx_s == S_DRAW_BG);
      ld_coord    <= (state_nx_s == S_GEN);
      ld_plot     <= (state_nx_s == S_DRAW);
      ld_erase    <= (state_nx_s == S_ERASE);
      round_done  <= (state_nx_s == S_DONE);
      busy        <= (state_nx_s != S_IDLE);
    end
  end

endmodule

// File: tb/tb_anim_sequencer.sv
// Bench for anim_sequencer: two parameter sets driven by shared stimulus, checked
// each cycle against a behavioural model, plus literal expectations for directed cases.
module tb_anim_sequencer;

  localparam int PH_IDLE = 0, PH_BG = 1, PH_GEN = 2, PH_DRAW = 3,
                 PH_WAIT = 4, PH_ERASE = 5, PH_CLEAR = 6, PH_DONE = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, go, black, hit, clr_done, bg_done, plot_done, frame_tick;
  logic [1:0] ld_clear_s, ld_bg_s, ld_coord_s, ld_plot_s, ld_erase_s, round_done_s, busy_s;
  logic [1:0] chan0_s;
  logic [0:0] chan1_s;
  logic [7:0] step0_s, step1_s;

  anim_sequencer #(.NUM_CH(4), .CH_W(2), .FRAME_DIV(2), .STEPS(3), .STEP_W(8)) u0 (
    .clk(clk), .reset(reset), .go(go), .black(black), .hit(hit), .clr_done(clr_done),
    .bg_done(bg_done), .plot_done(plot_done), .frame_tick(frame_tick),
    .ld_clear(ld_clear_s[0]), .ld_bg(ld_bg_s[0]), .ld_coord(ld_coord_s[0]),
    .ld_plot(ld_plot_s[0]), .ld_erase(ld_erase_s[0]), .chan(chan0_s), .step(step0_s),
    .round_done(round_done_s[0]), .busy(busy_s[0]));

  anim_sequencer #(.NUM_CH(1), .CH_W(1), .FRAME_DIV(1), .STEPS(1), .STEP_W(8)) u1 (
    .clk(clk), .reset(reset), .go(go), .black(black), .hit(hit), .clr_done(clr_done),
    .bg_done(bg_done), .plot_done(plot_done), .frame_tick(frame_tick),
    .ld_clear(ld_clear_s[1]), .ld_bg(ld_bg_s[1]), .ld_coord(ld_coord_s[1]),
    .ld_plot(ld_plot_s[1]), .ld_erase(ld_erase_s[1]), .chan(chan1_s), .step(step1_s),
    .round_done(round_done_s[1]), .busy(busy_s[1]));

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  bit cmp_en = 1'b0;

  int p_nch[2]   = '{4, 1};
  int p_fdiv[2]  = '{2, 1};
  int p_steps[2] = '{3, 1};

  int m_phase[2], m_chan[2], m_step[2], m_frame[2];
  bit m_hit[2], m_black[2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance the model one clock using the inputs the DUT samples on that edge.
  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_phase[i] = PH_IDLE; m_chan[i] = 0; m_step[i] = 0; m_frame[i] = 0;
        m_hit[i] = 1'b0; m_black[i] = 1'b0;
      end else begin
        case (m_phase[i])
          PH_IDLE: if (go) begin
            m_phase[i] = PH_BG; m_chan[i] = 0; m_step[i] = 0; m_frame[i] = 0;
            m_hit[i] = 1'b0; m_black[i] = 1'b0;
          end
          PH_BG: if (bg_done) begin m_phase[i] = PH_GEN; m_chan[i] = 0; end
          PH_GEN: begin
            m_chan[i]++;
            if (m_chan[i] == p_nch[i]) begin m_chan[i] = 0; m_phase[i] = PH_DRAW; end
          end
          PH_DRAW, PH_ERASE: begin
            m_hit[i] |= hit; m_black[i] |= black;
            if (plot_done) begin
              m_chan[i]++;
              if (m_chan[i] == p_nch[i]) begin
                m_chan[i] = 0;
                m_phase[i] = (m_phase[i] == PH_DRAW) ? PH_WAIT : PH_GEN;
              end
            end
          end
          PH_WAIT: begin
            if (frame_tick) m_frame[i]++;
            if (m_frame[i] == p_fdiv[i]) begin
              m_frame[i] = 0;
              m_step[i] = (m_step[i] + 1 > p_steps[i]) ? p_steps[i] : m_step[i] + 1;
              if (m_hit[i] || m_step[i] == p_steps[i]) m_phase[i] = PH_DONE;
              else if (m_black[i]) m_phase[i] = PH_CLEAR;
              else m_phase[i] = PH_ERASE;
              m_hit[i] = 1'b0; m_black[i] = 1'b0;
            end else begin
              m_hit[i] |= hit; m_black[i] |= black;
            end
          end
          PH_CLEAR: if (clr_done) m_phase[i] = PH_BG;
          PH_DONE:  m_phase[i] = PH_IDLE;
          default:  m_phase[i] = PH_IDLE;
        endcase
      end
    end
  endtask

  function automatic logic [18:0] exp_vec(input int i);
    int ph;
    ph = m_phase[i];
    return {ph == PH_CLEAR, ph == PH_BG, ph == PH_GEN, ph == PH_DRAW, ph == PH_ERASE,
            ph == PH_DONE, ph != PH_IDLE, 4'(m_chan[i]), 8'(m_step[i])};
  endfunction

  function automatic logic [18:0] act_vec(input int i);
    logic [3:0] c;
    logic [7:0] s;
    c = (i == 0) ? {2'b00, chan0_s} : {3'b000, chan1_s};
    s = (i == 0) ? step0_s : step1_s;
    return {ld_clear_s[i], ld_bg_s[i], ld_coord_s[i], ld_plot_s[i], ld_erase_s[i],
            round_done_s[i], busy_s[i], c, s};
  endfunction

  // per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL model_u%0d cycle %0d: got %h, expected %h", i, cyc_n, act_vec(i), exp_vec(i));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic clr_in();
    go = 1'b0; black = 1'b0; hit = 1'b0; clr_done = 1'b0;
    bg_done = 1'b0; plot_done = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  int n_coord[2], n_plot[2], n_erase[2], n_wait[2], n_rd[2], step_at_rd[2], bad_chan[2];

  initial begin
    reset = 1'b0;
    clr_in();
    ticks(2);
    cmp_en = 1'b1;
    chk("reset_busy", busy_s[0], 0);
    chk("reset_step", step0_s, 0);
    reset = 1'b1;
    tick();

    // fast round: every handshake and tick asserted each cycle
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("go_to_bg", ld_bg_s[0], 1);
    bg_done = 1'b1; plot_done = 1'b1; frame_tick = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_coord[i] = 0; n_plot[i] = 0; n_erase[i] = 0; n_wait[i] = 0;
      n_rd[i] = 0; step_at_rd[i] = -1; bad_chan[i] = 0;
    end
    for (int k = 0; k < 45; k++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (ld_coord_s[i]) begin
          if (((i == 0) ? int'(chan0_s) : int'(chan1_s)) != n_coord[i] % p_nch[i]) bad_chan[i]++;
          n_coord[i]++;
        end
        if (ld_plot_s[i]) n_plot[i]++;
        if (ld_erase_s[i]) n_erase[i]++;
        if (busy_s[i] && !round_done_s[i] &&
            ({ld_clear_s[i], ld_bg_s[i], ld_coord_s[i], ld_plot_s[i], ld_erase_s[i]} == 5'b0))
          n_wait[i]++;
        if (round_done_s[i]) begin
          n_rd[i]++;
          step_at_rd[i] = (i == 0) ? int'(step0_s) : int'(step1_s);
        end
      end
    end
    clr_in();
    chk("fast_coord_cycles", n_coord[0], 12);
    chk("fast_gen_chan_order", bad_chan[0], 0);
    chk("fast_plot_cycles", n_plot[0], 12);
    chk("fast_erase_cycles", n_erase[0], 8);
    chk("fast_wait_cycles", n_wait[0], 6);
    chk("fast_round_done", n_rd[0], 1);
    chk("fast_step_at_done", step_at_rd[0], 3);
    chk("fast_idle_after", busy_s[0], 0);
    chk("ch1_coord_cycles", n_coord[1], 1);
    chk("ch1_plot_cycles", n_plot[1], 1);
    chk("ch1_erase_cycles", n_erase[1], 0);
    chk("ch1_wait_cycles", n_wait[1], 1);
    chk("ch1_round_done", n_rd[1], 1);
    chk("ch1_step_at_done", step_at_rd[1], 1);
    chk("ch1_chan_zero", bad_chan[1], 0);

    // black during DRAW of step 0 leads to CLEAR, then redraw
    go = 1'b1; tick(); clr_in();
    bg_done = 1'b1; tick(); clr_in();
    ticks(4);
    chk("blk_in_draw", ld_plot_s[0], 1);
    black = 1'b1; tick(); clr_in();
    plot_done = 1'b1; ticks(4); clr_in();
    frame_tick = 1'b1; ticks(2); clr_in();
    chk("blk_clear", ld_clear_s[0], 1);
    chk("blk_step", step0_s, 1);
    ticks(3);
    chk("blk_clear_hold", ld_clear_s[0], 1);
    clr_done = 1'b1; tick(); clr_in();
    chk("blk_redraw_bg", ld_bg_s[0], 1);
    bg_done = 1'b1; tick(); clr_in();
    chk("blk_gen", ld_coord_s[0], 1);
    chk("blk_step_kept", step0_s, 1);

    // reset in the middle of DRAW at chan 2
    ticks(4);
    plot_done = 1'b1; ticks(2); clr_in();
    chk("rst_pre_chan", chan0_s, 2);
    reset = 1'b0; tick(); reset = 1'b1;
    chk("rst_busy", busy_s[0], 0);
    chk("rst_outputs", {ld_clear_s[0], ld_bg_s[0], ld_coord_s[0], ld_plot_s[0], ld_erase_s[0], round_done_s[0]}, 0);
    chk("rst_chan", chan0_s, 0);
    plot_done = 1'b1; tick(); clr_in();
    chk("rst_plot_ignored", busy_s[0], 0);

    // hit and black together in WAIT: DONE wins over CLEAR
    go = 1'b1; tick(); clr_in();
    bg_done = 1'b1; tick(); clr_in();
    ticks(4);
    plot_done = 1'b1; ticks(4); clr_in();
    hit = 1'b1; black = 1'b1; tick(); clr_in();
    frame_tick = 1'b1; ticks(2); clr_in();
    chk("hit_done", round_done_s[0], 1);
    chk("hit_no_clear", ld_clear_s[0], 0);
    chk("hit_step", step0_s, 1);
    tick();
    chk("hit_done_pulse", round_done_s[0], 0);
    chk("hit_idle", busy_s[0], 0);

    // stray go / bg_done / frame_tick outside their states
    go = 1'b1; tick(); clr_in();
    bg_done = 1'b1; tick(); clr_in();
    ticks(4);
    go = 1'b1; bg_done = 1'b1; frame_tick = 1'b1; tick(); clr_in();
    chk("stray_draw_hold", ld_plot_s[0], 1);
    chk("stray_draw_chan", chan0_s, 0);
    plot_done = 1'b1; ticks(4); clr_in();
    bg_done = 1'b1; tick(); clr_in();
    frame_tick = 1'b1; tick(); clr_in();
    chk("stray_still_wait", {busy_s[0], ld_erase_s[0], ld_bg_s[0]}, 3'b100);
    frame_tick = 1'b1; tick(); clr_in();
    chk("stray_erase", ld_erase_s[0], 1);
    chk("stray_step", step0_s, 1);

    // randomized traffic, including occasional resets
    for (int k = 0; k < 4000; k++) begin
      reset      = ($urandom_range(199, 0) != 0);
      go         = ($urandom_range(7, 0) == 0);
      bg_done    = ($urandom_range(3, 0) == 0);
      plot_done  = ($urandom_range(1, 0) == 0);
      frame_tick = ($urandom_range(2, 0) == 0);
      clr_done   = ($urandom_range(3, 0) == 0);
      black      = ($urandom_range(15, 0) == 0);
      hit        = ($urandom_range(23, 0) == 0);
      tick();
    end
    reset = 1'b1;
    clr_in();
    ticks(2);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/anim_sequencer.md
# anim_sequencer

Parametrised animation controller for the VGA game pipeline. It sequences the pixel datapath through background draw, per-channel coordinate generation, sprite plot, frame-paced wait, sprite erase, and optional full-screen clear. It handles NUM_CH independent sprite channels instead of one. It sits between the game-logic inputs (go/black/hit) and the drawing datapath, and handshakes with the datapath through done pulses.

## Interface
- NUM_CH, 4: number of sprite channels, 1..16.
- CH_W, 2: width of chan; must be ≥ max(1, clog2(NUM_CH)).
- FRAME_DIV, 4: frame_tick pulses per animation step, 1..255.
- STEPS, 60: animation steps per round, 1..2^STEP_W-1.
- STEP_W, 8: width of step counter.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low; clock clk.
- go  in  1  start round; honoured only in IDLE.
- black  in  1  request full-screen clear; sticky-latched, honoured at step boundary.
- hit  in  1  end round early; sticky-latched, honoured at step boundary.
- clr_done  in  1  datapath finished screen clear (1-cycle pulse).
- bg_done  in  1  datapath finished background draw (pulse).
- plot_done  in  1  datapath finished one sprite plot or erase (pulse).
- frame_tick  in  1  one-cycle pulse per VGA frame.
- ld_clear, ld_bg, ld_coord, ld_plot, ld_erase  out  1 each  datapath enables, one-hot or all zero.
- chan  out  CH_W  active sprite channel.
- step  out  STEP_W  completed-step count in current round.
- round_done  out  1  one-cycle pulse when round ends.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, DRAW_BG, GEN, DRAW, WAIT, ERASE, CLEAR, DONE.
- Outputs are Moore-decoded from state. ld_bg is driven in DRAW_BG, ld_coord in GEN, ld_plot in DRAW, ld_erase in ERASE, ld_clear in CLEAR, and round_done in DONE.
- IDLE: when go=1, go to DRAW_BG and clear step, frame_cnt, chan, hit_q and black_q.
- DRAW_BG: when bg_done=1, go to GEN with chan=0.
- GEN: lasts one cycle per channel, with chan counting 0..NUM_CH-1. After the last channel, go to DRAW with chan=0.
- DRAW: on each plot_done, increment chan. On the plot_done where chan=NUM_CH-1, go to WAIT with chan=0.
- WAIT: count frame_tick. When frame_tick=1 and frame_cnt=FRAME_DIV-1, set frame_cnt=0, step=step+1, and take the first matching exit:
  - hit_q, or step+1=STEPS: go to DONE.
  - black_q: go to CLEAR.
  - otherwise: go to ERASE.
- ERASE: channel iteration is identical to DRAW. After the last channel, go to GEN.
- CLEAR: when clr_done=1, go to DRAW_BG. step is preserved.
- DONE: one cycle, then go to IDLE.
- hit_q and black_q:
  - Set whenever the input is high in DRAW, WAIT or ERASE.
  - Both are cleared on any WAIT exit.
  - An input that is high on the exit cycle itself is not latched; it must be re-asserted.
- Done pulses arriving in a state that does not consume them are ignored. go outside IDLE is ignored. frame_tick outside WAIT is ignored, and frame_cnt holds.
- step saturates at STEPS; it never wraps.

## Timing
- Reset (reset=0 at a clock edge) has priority over everything. On the next cycle:
  - State is IDLE; all ld_* are 0; chan=0; step=0; frame_cnt=0.
  - round_done=0, busy=0, hit_q=0, black_q=0.
- This applies mid-operation too: any in-flight handshake is abandoned.
- go sampled high at edge t gives ld_bg=1 in cycle t+1.
- bg_done sampled at edge k gives ld_coord=1 in cycles k+1..k+NUM_CH with chan=0..NUM_CH-1, then ld_plot=1 from cycle k+NUM_CH+1.
- A done pulse advances chan or state on the same edge it is sampled. A back-to-back plot_done every cycle therefore completes DRAW in NUM_CH cycles.
- A qualifying frame_tick sampled at edge w updates the step output, and the exit state is entered, in cycle w+1.
- round_done is high exactly one cycle; busy drops the following cycle.
- NUM_CH=1: GEN lasts one cycle, and chan stays 0 throughout.

## Test plan
Unless noted, parameters are NUM_CH=4, FRAME_DIV=2, STEPS=3.
- Reset mid-DRAW (chan=2) -> next cycle IDLE, all outputs 0, busy=0; plot_done afterwards is ignored.
- go, bg_done, plot_done every cycle, frame_tick every cycle:
  - ld_coord is high 4 cycles with chan 0,1,2,3; ld_plot is high 4 cycles.
  - WAIT lasts 2 ticks, then ERASE for 4 cycles, then GEN.
  - step reads 1, 2, then 3 with round_done pulse; then IDLE.
- black pulsed during DRAW of step 0 -> after WAIT, CLEAR with ld_clear=1 until clr_done, then DRAW_BG, then GEN; step=1 is preserved.
- hit and black both pulsed in WAIT -> DONE, not CLEAR; round_done high 1 cycle, step=1.
- go during DRAW and bg_done during WAIT -> no effect on state or counters; frame_tick in DRAW does not advance frame_cnt.
- NUM_CH=1, FRAME_DIV=1, STEPS=1 -> after bg_done: GEN 1 cycle, DRAW until one plot_done, WAIT until first frame_tick, then DONE; chan=0 throughout.
